// File: rtl/regfile_wb_queue_if.sv
// Bundled ports of the register-file writeback queue: producer handshakes,
// register-file write port, decode hazard/forwarding probes and status.
interface regfile_wb_queue_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;

    logic              wb_slot;
    logic              write_enable;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] data_in;

    logic [ADDR_W-1:0] chk_addr1;
    logic [ADDR_W-1:0] chk_addr2;
    logic              hazard1;
    logic              hazard2;
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;

    logic [CW-1:0]     count;
    logic              drop_err;

    // Producer / register-file / decode side.
    modport master (
        output mem_valid, mem_addr, mem_data, input mem_ready,
        output alu_valid, alu_addr, alu_data, input alu_ready,
        output wb_slot, input write_enable, write_address, data_in,
        output chk_addr1, chk_addr2,
        input  hazard1, hazard2, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
        input  count, drop_err
    );

    // Queue side.
    modport slave (
        input  mem_valid, mem_addr, mem_data, output mem_ready,
        input  alu_valid, alu_addr, alu_data, output alu_ready,
        input  wb_slot, output write_enable, write_address, data_in,
        input  chk_addr1, chk_addr2,
        output hazard1, hazard2, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
        output count, drop_err
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order writeback queue in front of the register-file write port, with
// pending-write hazard detection. Define REGFILE_WB_FWD_EN to enable forwarding.
module regfile_wb_queue #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int MAX_REG = 23
) (
    input logic              clk,
    input logic              rst,
    regfile_wb_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] MAX_A  = ADDR_W'(MAX_REG);
    localparam logic [CW-1:0]     FULL   = CW'(DEPTH);
    localparam logic [CW-1:0]     ONE_LT = CW'(DEPTH - 1);
    localparam logic [CW-1:0]     TWO_LT = CW'(DEPTH - 2);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t          slots_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic            drop_q, drop_d;

    logic            mem_fire, alu_fire;
    logic            mem_keep, alu_keep;
    logic            pop;
    logic [PW-1:0]   alu_slot;
    logic [CW-1:0]   pushes;

    // Readiness looks only at the registered count, so a same-cycle pop never frees space early.
    assign bus.mem_ready = (count_q < FULL);
    assign bus.alu_ready = (count_q <= TWO_LT) | ((count_q == ONE_LT) & ~bus.mem_valid);

    assign mem_fire = bus.mem_valid & bus.mem_ready;
    assign alu_fire = bus.alu_valid & bus.alu_ready;
    assign mem_keep = mem_fire & (bus.mem_addr <= MAX_A);
    assign alu_keep = alu_fire & (bus.alu_addr <= MAX_A);
    assign pop      = bus.wb_slot & (count_q != '0);

    // The load is older, so it takes tail and the ALU result lands behind it.
    assign alu_slot = tail_q + PW'(mem_keep);
    assign pushes   = CW'(mem_keep) + CW'(alu_keep);

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(pushes);
        count_d = count_q + pushes - CW'(pop);
        drop_d  = (mem_fire & ~mem_keep) | (alu_fire & ~alu_keep);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // NOTE: the entry storage is deliberately not reset; occupancy is tracked by count_q, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (mem_keep) slots_q[tail_q]   <= '{addr: bus.mem_addr, data: bus.mem_data};
            if (alu_keep) slots_q[alu_slot] <= '{addr: bus.alu_addr, data: bus.alu_data};
        end
    end

    assign bus.write_enable  = (count_q != '0);
    assign bus.write_address = bus.write_enable ? slots_q[head_q].addr : '0;
    assign bus.data_in       = bus.write_enable ? slots_q[head_q].data : '0;
    assign bus.count         = count_q;
    assign bus.drop_err      = drop_q;

    // Walk entries oldest to youngest; only the first count_q of them are live.
    logic          hit1, hit2;
    logic [PW-1:0] idx;

    // NOTE: every variable assigned in this always_comb gets a default first, so no latch is inferred.
    always_comb begin
        hit1 = 1'b0;
        hit2 = 1'b0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (slots_q[idx].addr == bus.chk_addr1) hit1 = 1'b1;
                if (slots_q[idx].addr == bus.chk_addr2) hit2 = 1'b1;
            end
        end
    end

    assign bus.hazard1 = hit1 & (bus.chk_addr1 <= MAX_A);
    assign bus.hazard2 = hit2 & (bus.chk_addr2 <= MAX_A);

`ifdef REGFILE_WB_FWD_EN
    logic [DATA_W-1:0] fdata1, fdata2;
    logic [PW-1:0]     fidx;

    // Later (younger) matches overwrite earlier ones, leaving the entry closest to tail.
    always_comb begin
        fdata1 = '0;
        fdata2 = '0;
        fidx   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fidx = head_q + PW'(k);
            if (CW'(k) < count_q) begin
                if (slots_q[fidx].addr == bus.chk_addr1) fdata1 = slots_q[fidx].data;
                if (slots_q[fidx].addr == bus.chk_addr2) fdata2 = slots_q[fidx].data;
            end
        end
    end

    assign bus.fwd1_hit  = bus.hazard1;
    assign bus.fwd2_hit  = bus.hazard2;
    assign bus.fwd1_data = bus.hazard1 ? fdata1 : '0;
    assign bus.fwd2_data = bus.hazard2 ? fdata2 : '0;
`else
    assign bus.fwd1_hit  = 1'b0;
    assign bus.fwd2_hit  = 1'b0;
    assign bus.fwd1_data = '0;
    assign bus.fwd2_data = '0;
`endif

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Writeback initiator for the 32x32 register file. It accepts completed results from the ALU and the load path and buffers them in an in-order queue. It drives the register file's write port (`write_enable`, `write_address`, `data_in`) one entry per commit slot, and reports pending-write hazards for the two decode read addresses. It sits between the execute/memory stages and the register file's write side.

## Interface
Parameters:
- `DEPTH`, 4, queue entries; power of two, 2..16
- `DATA_W`, 32, result width
- `ADDR_W`, 5, register address width
- `MAX_REG`, 23, highest implemented register; addresses above it are discarded

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `mem_valid`  in  1  load result offered
- `mem_addr`  in  ADDR_W  load destination register
- `mem_data`  in  DATA_W  load result
- `mem_ready`  out  1  load result accepted when `mem_valid & mem_ready`
- `alu_valid`  in  1  ALU result offered
- `alu_addr`  in  ADDR_W  ALU destination register
- `alu_data`  in  DATA_W  ALU result
- `alu_ready`  out  1  ALU result accepted when `alu_valid & alu_ready`
- `wb_slot`  in  1  register-file commit strobe; one write commits per cycle with `wb_slot` high
- `write_enable`  out  1  head entry valid
- `write_address`  out  ADDR_W  head destination
- `data_in`  out  DATA_W  head data
- `chk_addr1`, `chk_addr2`  in  ADDR_W  decode read addresses
- `hazard1`, `hazard2`  out  1  a queued write targets `chk_addrN`
- `fwd1_hit`, `fwd2_hit`  out  1  forwarding hit (see Configuration)
- `fwd1_data`, `fwd2_data`  out  DATA_W  forwarded value
- `count`  out  $clog2(DEPTH)+1  occupied entries
- `drop_err`  out  1  one-cycle pulse: an accepted result was discarded

## Operation
- Circular buffer with `head` and `tail` pointers, both `$clog2(DEPTH)` bits and wrapping modulo DEPTH, plus a `count` register.
- Ready logic is combinational from the registered `count` only. Space freed by a same-cycle pop is not visible until the next cycle.
  - `free = DEPTH - count`.
  - `mem_ready = (free >= 1)`.
  - `alu_ready = (free >= 2) | (free == 1 & !mem_valid)`.
- Ordering: when both handshakes fire in one cycle, the mem entry is written at `tail`, then the alu entry at `tail+1`. The load belongs to the older instruction.
- Discard rule: a handshaked result with address > `MAX_REG` is accepted but not enqueued, and `drop_err` pulses the next cycle. If both producers are discarded in the same cycle, it is a single pulse. The remaining valid result takes slot `tail`.
- Pop: `wb_slot & write_enable` pops the head. Push and pop in the same cycle update `count` by (pushes - 1).
- Outputs: `write_enable = (count != 0)`. `write_address` and `data_in` come from the head entry and read 0 when empty.
- Hazards:
  - `hazardN = 1` if any occupied entry has `addr == chk_addrN`.
  - Evaluation is combinational and covers occupied entries only. Incoming, not-yet-registered results are not included.
  - Addresses > `MAX_REG` never flag a hazard.
- Address 0 is an ordinary register and is queued and committed like any other.

## Timing
- Reset values: `count` = 0, pointers = 0, `write_enable` = 0, `write_address` = 0, `data_in` = 0, `drop_err` = 0, `hazardN` = 0, `fwdN_hit` = 0, `fwdN_data` = 0.
- `rst` overrides everything in the same cycle. Queued entries are lost and no write is presented the following cycle.
- Push-to-head latency: a result accepted at edge N into an empty queue appears on `write_enable`/`write_address`/`data_in` after edge N, in cycle N+1.
- Throughput: at most 2 pushes and 1 pop per cycle.
- Full (`count == DEPTH`): both readies are low. A `wb_slot` in that cycle pops, and readiness returns the next cycle.
- Empty with `wb_slot` high: no effect.

## Configuration
- `REGFILE_WB_FWD_EN` defined:
  - `fwdN_hit` = `hazardN`.
  - `fwdN_data` = data of the youngest occupied entry matching `chk_addrN`, where youngest means closest to `tail`.
  - Decode may use the forwarded value instead of stalling.
- Not defined: `fwdN_hit` and `fwdN_data` are tied to 0. The ports remain, so the interface is unchanged.

## Test plan
- Reset then single ALU push (r5, 0x1234): `write_enable` high next cycle with r5/0x1234. Pulse `wb_slot`: `count` returns to 0 and `write_enable` drops.
- Simultaneous mem (r3, 0xAAAA) and alu (r3, 0xBBBB) into an empty queue:
  - Commit order is 0xAAAA then 0xBBBB.
  - `hazard1` is high for `chk_addr1` = 3 until both commit.
  - With the macro defined, `fwd1_data` = 0xBBBB.
- Fill to DEPTH = 4 with no `wb_slot`:
  - Both readies are low.
  - With 3 entries and `mem_valid` high, `alu_ready` = 0.
  - A push and a pop in the same cycle hold `count` constant.
- ALU push to r27: accepted, not queued, `count` unchanged, `drop_err` high for exactly 1 cycle, `hazard1` = 0 for `chk_addr1` = 27.
- Pointer wrap: 10 back-to-back push/pop pairs with distinct data commit in exact order.
- Reset asserted with 3 entries queued: the next cycle shows `count` = 0, `write_enable` = 0, and all hazards low.
